keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_tick_gen.sv | 27 ++
 rtl/keypad_scan.sv | 143 ++++++++++++++
 tb/tb_keypad_scan.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned KP_N = 4;
    localparam logic [KP_N-1:0] KP_IDLE = '1;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } kp_state_e;

    // Index of the lowest-numbered row reading low; 0 when none is low.
    function automatic logic [1:0] lowest_low(input logic [KP_N-1:0] rows);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < KP_N; i++) begin
            if (!rows[i] && !found) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, on the last count.
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column rotation, row synchronizer, press/release
// debounce FSM, one-cycle key_valid strobe per accepted press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEBOUNCE_N = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [KP_N-1:0] row,
    output logic [KP_N-1:0] col,
    output key_code_t       key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int unsigned CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_N);

    kp_state_e       r_state, w_state_nx;
    logic [KP_N-1:0] r_row_s1, r_row_s2;
    logic [1:0]      r_col_idx, w_col_nx;
    logic [1:0]      r_row_idx, w_row_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
    key_code_t       r_code, w_code_nx;
    logic            r_valid, w_valid_nx;
    logic            w_tick;
    logic            w_row_hit;
    logic [1:0]      w_low_idx;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    // Synchronizer resets to the idle (no key) pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1  <= KP_IDLE;
            r_row_s2  <= KP_IDLE;
            r_state   <= ST_SCAN;
            r_col_idx <= '0;
            r_row_idx <= '0;
            r_cnt     <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_row_s1  <= row;
            r_row_s2  <= r_row_s1;
            r_state   <= w_state_nx;
            r_col_idx <= w_col_nx;
            r_row_idx <= w_row_nx;
            r_cnt     <= w_cnt_nx;
            r_code    <= w_code_nx;
            r_valid   <= w_valid_nx;
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_row_hit = ~r_row_s2[r_row_idx];
    assign w_low_idx = lowest_low(r_row_s2);

    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col_idx;
        w_row_nx   = r_row_idx;
        w_cnt_nx   = r_cnt;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (r_row_s2 != KP_IDLE) begin
                        w_row_nx = w_low_idx;
                        w_cnt_nx = CW'(1);
                        // A single-sample debounce accepts on the first hit.
                        if (CNT_DONE == CW'(1)) begin
                            w_state_nx = ST_PRESSED;
                            w_code_nx  = {w_low_idx, r_col_idx};
                            w_valid_nx = 1'b1;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = ST_DEBOUNCE;
                        end
                    end else begin
                        w_col_nx = r_col_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_row_hit) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            w_state_nx = ST_PRESSED;
                            w_code_nx  = {r_row_idx, r_col_idx};
                            w_valid_nx = 1'b1;
                            w_cnt_nx   = '0;
                        end
                    end else begin
                        w_state_nx = ST_SCAN;
                        w_col_nx   = r_col_idx + 2'd1;
                        w_cnt_nx   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!w_row_hit) begin
                        if (CNT_DONE == CW'(1)) begin
                            w_state_nx = ST_SCAN;
                            w_col_nx   = r_col_idx + 2'd1;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = ST_RELEASE;
                            w_cnt_nx   = CW'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (w_row_hit) begin
                        w_state_nx = ST_PRESSED;
                        w_cnt_nx   = '0;
                    end else if (w_cnt_inc == CNT_DONE) begin
                        w_state_nx = ST_SCAN;
                        w_col_nx   = r_col_idx + 2'd1;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nx = ST_SCAN;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    assign col       = ~(4'b0001 << r_col_idx);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: behavioural 4x4 key matrix, scoreboard of expected codes.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic [3:0] last_code;

    typedef struct {
        logic [15:0] mask;
        logic [1:0]  acol;
        int          hold;
        logic        expv;
        logic [3:0]  code;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    // Key index r*4+c shorts row r to column c while that column is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col[c] == 1'b0 && keys[r*4+c]) row[r] = 1'b0;
            end
        end
    end

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    function automatic logic [3:0] col_pat(input logic [1:0] c);
        logic [3:0] p;
        p    = 4'b1111;
        p[c] = 1'b0;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        logic [3:0] e;
        @(negedge clk);
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'(key_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_key_code", 32'(key_code), 32'(e));
            end
            chk("valid_not_consecutive", 32'(prev_valid), 32'd0);
        end
        prev_valid = rst ? 1'b0 : key_valid;
    endtask

    // Returns at the first negedge after col switched to column c (a tick edge).
    task automatic wait_col_fresh(input logic [1:0] c);
        int n;
        n = 0;
        while (col == col_pat(c) && n < 64) begin step(); n++; end
        while (col != col_pat(c) && n < 128) begin step(); n++; end
        chk("col_align", 32'(col), 32'(col_pat(c)));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (key_held && n < 100) begin step(); n++; end
        chk("held_release", 32'(key_held), 32'd0);
    endtask

    initial begin
        vecs[0] = '{mask: 16'h0001, acol: 2'd0, hold: 14, expv: 1'b1, code: 4'd0};
        vecs[1] = '{mask: 16'h8000, acol: 2'd3, hold: 14, expv: 1'b1, code: 4'd15};
        vecs[2] = '{mask: 16'h2020, acol: 2'd1, hold: 14, expv: 1'b1, code: 4'd5};
        vecs[3] = '{mask: 16'h0044, acol: 2'd2, hold: 14, expv: 1'b1, code: 4'd2};
        vecs[4] = '{mask: 16'h0080, acol: 2'd3, hold: 4,  expv: 1'b0, code: 4'd0};
        vecs[5] = '{mask: 16'h0200, acol: 2'd1, hold: 8,  expv: 1'b0, code: 4'd0};
        vecs[6] = '{mask: 16'h0800, acol: 2'd3, hold: 10, expv: 1'b1, code: 4'd11};

        keys = '0;
        rst  = 1'b1;
        last_code = 4'd0;

        // Reset state and column rotation with no key.
        repeat (5) @(negedge clk);
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("rotate_col", 32'(col), 32'(col_pat(2'((k / 4) % 4))));
            chk("rotate_valid", 32'(key_valid), 32'd0);
        end

        // Key 10: strobe timing and release delay.
        wait_col_fresh(2'd2);
        keys = 16'h0400;
        exp_q.push_back(4'd10);
        repeat (11) step();
        chk("latency_early", 32'(key_valid), 32'd0);
        step();
        chk("latency_valid", 32'(key_valid), 32'd1);
        chk("pressed_held", 32'(key_held), 32'd1);
        keys = '0;
        step();
        chk("valid_one_cycle", 32'(key_valid), 32'd0);
        repeat (10) step();
        chk("release_still_held", 32'(key_held), 32'd1);
        step();
        chk("release_held_low", 32'(key_held), 32'd0);
        chk("release_next_col", 32'(col), 32'(col_pat(2'd3)));
        chk("code_10", 32'(key_code), 32'd10);
        last_code = 4'd10;

        // One-tick bounce on row 1 in column 0.
        wait_col_fresh(2'd0);
        keys = 16'h0010;
        repeat (4) step();
        keys = '0;
        step();
        chk("bounce_hold_col", 32'(col), 32'(col_pat(2'd0)));
        repeat (3) step();
        chk("bounce_next_col", 32'(col), 32'(col_pat(2'd1)));
        chk("bounce_no_held", 32'(key_held), 32'd0);

        for (int v = 0; v < 7; v++) begin
            wait_col_fresh(vecs[v].acol);
            keys = vecs[v].mask;
            if (vecs[v].expv) exp_q.push_back(vecs[v].code);
            repeat (vecs[v].hold) step();
            keys = '0;
            repeat (16) step();
            wait_idle();
            chk("sb_drain", 32'(exp_q.size()), 32'd0);
            if (vecs[v].expv) last_code = vecs[v].code;
            chk("code_hold", 32'(key_code), 32'(last_code));
        end

        // One-tick release glitch while pressed.
        wait_col_fresh(2'd1);
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        repeat (12) step();
        chk("glitch_valid", 32'(key_valid), 32'd1);
        keys = '0;
        repeat (5) step();
        chk("glitch_held_mid", 32'(key_held), 32'd1);
        keys = 16'h0200;
        repeat (13) step();
        chk("glitch_held_after", 32'(key_held), 32'd1);
        chk("glitch_col", 32'(col), 32'(col_pat(2'd1)));
        keys = '0;
        repeat (16) step();
        wait_idle();
        chk("glitch_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while pressed.
        wait_col_fresh(2'd2);
        keys = 16'h4000;
        exp_q.push_back(4'd14);
        repeat (12) step();
        chk("arst_pre_valid", 32'(key_valid), 32'd1);
        repeat (3) step();
        chk("arst_pre_held", 32'(key_held), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_col", 32'(col), 32'hE);
        chk("arst_held", 32'(key_held), 32'd0);
        chk("arst_valid", 32'(key_valid), 32'd0);
        chk("arst_code", 32'(key_code), 32'd0);
        repeat (20) step();
        chk("arst_hold_held", 32'(key_held), 32'd0);
        keys = '0;
        repeat (4) step();
        rst = 1'b0;
        repeat (40) step();
        chk("arst_drain", 32'(exp_q.size()), 32'd0);
        chk("arst_code_after", 32'(key_code), 32'd0);
        chk("arst_held_after", 32'(key_held), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
